// File: rtl/control_unit.sv
// control_unit -- instruction-sequencing stage downstream of the fetch unit.
//
// Waits for a completed fetch, latches the instruction into IR, decodes it
// and drives register-file writes and the data-memory handshake. It tells the
// fetch unit when to advance or redirect the PC. It also holds the carry flag
// and the halt state.
//
// Optional feature macro: CONTROL_ILLEGAL_TRAP_EN
//   defined   : an illegal instruction pulses illegal_inst and halts the CPU
//   undefined : an illegal instruction retires as a NOP; illegal_inst is 0
//
// Ports:
//   clk, rst_async        clock, asynchronous active-high reset
//   fetch_complete, inst  completed fetch and its 16-bit instruction
//   fetch_operation       FETCH_NOP / FETCH_INC_PC / FETCH_JUMP to fetch
//   jump_target           14-bit byte address, used with FETCH_JUMP
//   rd_val, r0, r6, r7    register-file reads (rd_val = read of IR rd)
//   rf_we/waddr/wdata     register-file write port
//   data_mem_*            data-memory request/ack handshake
//   carry, halted         architectural flag and halt status
//   illegal_inst          illegal-instruction pulse

package cpu_common;
  typedef enum logic [1:0] {
    FETCH_NOP    = 2'd0,
    FETCH_INC_PC = 2'd1,
    FETCH_JUMP   = 2'd2
  } fetch_operation_t;
endpackage

module control_unit (
  input  logic                         clk,
  input  logic                         rst_async,
  input  logic                         fetch_complete,
  input  logic [15:0]                  inst,
  output cpu_common::fetch_operation_t fetch_operation,
  output logic [13:0]                  jump_target,
  input  logic [7:0]                   rd_val,
  input  logic [7:0]                   r0,
  input  logic [7:0]                   r6,
  input  logic [7:0]                   r7,
  output logic                         rf_we,
  output logic [2:0]                   rf_waddr,
  output logic [7:0]                   rf_wdata,
  output logic                         data_mem_req,
  output logic                         data_mem_we,
  output logic [13:0]                  data_mem_addr,
  output logic [7:0]                   data_mem_wdata,
  input  logic                         data_mem_ack,
  input  logic [7:0]                   data_mem_rdata,
  output logic                         carry,
  output logic                         halted,
  output logic                         illegal_inst
);
  import cpu_common::*;

  typedef enum logic [2:0] {
    S_WAIT_FETCH, S_EXECUTE, S_MEM_WAIT, S_RETIRE, S_SETTLE, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_LI, OP_LD, OP_ST, OP_JMP, OP_HALT
  } opcode_t;

  state_t      r_state;
  logic [15:0] r_ir;
  logic        r_carry;
  logic [7:0]  r_ld_data;

  opcode_t     w_opcode;
  logic [2:0]  w_rd;
  logic [7:0]  w_imm;
  logic        w_illegal;
  logic [8:0]  w_add;
  logic [8:0]  w_sub;
  logic        w_unused;

  assign w_opcode  = opcode_t'(r_ir[7:5]);
  assign w_rd      = r_ir[4:2];
  assign w_imm     = r_ir[15:8];
  // Only LI and JMP are 2-byte; any other length bit is illegal.
  assign w_illegal = r_ir[1] != ((w_opcode == OP_LI) || (w_opcode == OP_JMP));
  assign w_add     = {1'b0, rd_val} + {1'b0, r0};
  // Bit 8 of the 9-bit difference is the borrow.
  assign w_sub     = {1'b0, rd_val} - {1'b0, r0};
  assign w_unused  = ^{r_ir[0], r6[7:6]};

  assign carry  = r_carry;
  assign halted = (r_state == S_HALTED);

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state   <= S_WAIT_FETCH;
      r_ir      <= '0;
      r_carry   <= 1'b0;
      r_ld_data <= '0;
    end else begin
      case (r_state)
        S_WAIT_FETCH: if (fetch_complete) begin
          r_ir    <= inst;
          r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (w_illegal) begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
            r_state <= S_HALTED;
`else
            r_state <= S_SETTLE;
`endif
          end else begin
            case (w_opcode)
              OP_ADD: begin r_carry <= w_add[8]; r_state <= S_SETTLE; end
              OP_SUB: begin r_carry <= w_sub[8]; r_state <= S_SETTLE; end
              OP_LD, OP_ST: begin
                if (data_mem_ack) begin
                  r_ld_data <= data_mem_rdata;
                  r_state   <= S_RETIRE;
                end else begin
                  r_state <= S_MEM_WAIT;
                end
              end
              OP_HALT: r_state <= S_HALTED;
              default: r_state <= S_SETTLE;
            endcase
          end
        end
        S_MEM_WAIT: if (data_mem_ack) begin
          r_ld_data <= data_mem_rdata;
          r_state   <= S_RETIRE;
        end
        S_RETIRE: r_state <= S_SETTLE;
        S_SETTLE: r_state <= S_WAIT_FETCH;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_WAIT_FETCH;
      endcase
    end
  end

  always_comb begin
    fetch_operation = FETCH_NOP;
    jump_target     = '0;
    rf_we           = 1'b0;
    rf_waddr        = '0;
    rf_wdata        = '0;
    data_mem_req    = 1'b0;
    data_mem_we     = 1'b0;
    data_mem_addr   = '0;
    data_mem_wdata  = '0;
    illegal_inst    = 1'b0;
    case (r_state)
      S_EXECUTE: begin
        if (w_illegal) begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
          illegal_inst = 1'b1;
`else
          fetch_operation = FETCH_INC_PC;
`endif
        end else begin
          case (w_opcode)
            OP_ADD: begin rf_we = 1'b1; rf_wdata = w_add[7:0]; fetch_operation = FETCH_INC_PC; end
            OP_SUB: begin rf_we = 1'b1; rf_wdata = w_sub[7:0]; fetch_operation = FETCH_INC_PC; end
            OP_XOR: begin rf_we = 1'b1; rf_wdata = rd_val ^ r0; fetch_operation = FETCH_INC_PC; end
            OP_LI:  begin rf_we = 1'b1; rf_wdata = w_imm;       fetch_operation = FETCH_INC_PC; end
            OP_LD, OP_ST: begin
              data_mem_req   = 1'b1;
              data_mem_we    = (w_opcode == OP_ST);
              data_mem_addr  = {r6[5:0], r7};
              data_mem_wdata = rd_val;
            end
            OP_JMP: begin
              fetch_operation = FETCH_JUMP;
              jump_target     = {r6[5:0], w_imm};
            end
            default: ;
          endcase
          rf_waddr = rf_we ? w_rd : 3'd0;
        end
      end
      S_MEM_WAIT: begin
        data_mem_req   = 1'b1;
        data_mem_we    = (w_opcode == OP_ST);
        data_mem_addr  = {r6[5:0], r7};
        data_mem_wdata = rd_val;
      end
      S_RETIRE: begin
        fetch_operation = FETCH_INC_PC;
        if (w_opcode == OP_LD) begin
          rf_we    = 1'b1;
          rf_waddr = w_rd;
          rf_wdata = r_ld_data;
        end
      end
      default: ;
    endcase
  end

endmodule
